// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the Aardvark 8-bit datapath: turns decoded
// control bits into timed PC/IR/memory/register-file strobes and arbitrates the shared memory port.
module cpu_sequencer #(
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [7:0]  HALT_INSTR  = 8'hFF,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [7:0]       instruction,
  input  logic             mem_ready,
  input  logic             ctrl_memRead,
  input  logic             ctrl_memWrite,
  input  logic             ctrl_regWrite,
  output logic             ir_load,
  output logic             pc_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic               step_prev_q, step_prev_d;
  logic               step_mode_q, step_mode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               step_rise;
  logic               timeout_hit;
  logic               retire;

  assign step_rise   = step & ~step_prev_q;
  // A request may sit unanswered for MEM_TIMEOUT cycles; one more unanswered cycle faults.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_HALT;
      step_prev_q   <= 1'b0;
      step_mode_q   <= 1'b0;
      wait_q        <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      step_prev_q   <= step_prev_d;
      step_mode_q   <= step_mode_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_prev_d  = step;
    step_mode_d  = step_mode_q;
    wait_d       = '0;
    retire       = 1'b0;
    ir_load      = 1'b0;
    pc_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    rf_we        = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    case (state_q)
      S_HALT: begin
        halted = 1'b1;
        if (run || step_rise) begin
          state_d     = S_FETCH;
          step_mode_d = step_rise;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          if (instruction == HALT_INSTR) begin
            state_d     = S_HALT;
            step_mode_d = 1'b0;
          end else begin
            state_d = S_DECODE;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (ctrl_memRead && ctrl_memWrite) begin
          state_d = S_FAULT;
        end else if (ctrl_memRead || ctrl_memWrite) begin
          state_d = S_MEM;
        end else if (ctrl_regWrite) begin
          state_d = S_WB;
        end else begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = ctrl_memWrite;
        if (mem_ready) begin
          if (ctrl_memRead && ctrl_regWrite) begin
            state_d = S_WB;
          end else begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      default: begin
        // FAULT and any stray encoding are sticky until reset.
        fault   = 1'b1;
        state_d = S_FAULT;
      end
    endcase
    if (retire) begin
      state_d     = (step_mode_q || !run) ? S_HALT : S_FETCH;
      step_mode_d = 1'b0;
    end
    instr_count_d = retire ? instr_count_q + 1'b1 : instr_count_q;
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule
